mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-ported unified memory between the CPU's instruction-fetch
//   port (IF) and data-memory port (DM) inside Top. Arbitrates, holds the memory
//   for MEM_LAT cycles and returns a one-cycle ack with read data.
//   DM has priority over IF, with a streak limit so that IF is never starved.
// PARAMETERS
//   ADDR_W     32  address width
//   DATA_W     32  data width
//   MEM_LAT    2   cycles mem_en is held per access (>=1); mem_rdata is valid in the last one
//   STARVE_MAX 4   max consecutive DM grants while if_req is pending (>=1)
// PORTS
//   CLOCK_IN   in   1       system clock; all state changes on the rising edge
//   RESET      in   1       asynchronous reset, active-low
//   if_req     in   1       IF read request; held with if_addr stable until if_ack
//   if_addr    in   ADDR_W  IF read address
//   if_ack     out  1       one-cycle pulse: IF access complete
//   if_rdata   out  DATA_W  IF read data; valid with if_ack, held until next IF ack
//   dm_req     in   1       DM request; held with dm_we/addr/wdata stable until dm_ack
//   dm_we      in   1       1 = write, 0 = read
//   dm_addr    in   ADDR_W  DM address
//   dm_wdata   in   DATA_W  DM write data
//   dm_ack     out  1       one-cycle pulse: DM access complete
//   dm_rdata   out  DATA_W  DM read data; updated only on DM read acks
//   mem_en     out  1       memory enable, high for the whole access
//   mem_we     out  1       memory write enable (DM writes only)
//   mem_addr   out  ADDR_W  latched address of the granted request
//   mem_wdata  out  DATA_W  latched write data
//   mem_rdata  in   DATA_W  memory read data
//   busy       out  1       high in ACCESS and RESP
//   owner      out  1       0 = IF, 1 = DM; valid while busy
// BEHAVIOUR
//   Reset (RESET=0, async): state IDLE, streak=0, lat_cnt=0, all outputs 0,
//     including the rdata registers. This takes effect immediately, even mid-access:
//     mem_en drops at once, no ack is issued and the aborted access is lost.
//   FSM:
//     IDLE   -> ACCESS when any req is high; latch owner, addr, we, wdata that edge
//     ACCESS -> mem_en=1, mem_we=(owner & we); lat_cnt counts 0..MEM_LAT-1;
//               in the last cycle, capture mem_rdata into the owner's rdata (skip on
//               writes) and go to RESP
//     RESP   -> the owner's ack=1 for exactly this cycle; no grant here; -> IDLE
//   Latency: grant edge to ack = MEM_LAT+1 cycles; one access per MEM_LAT+2 cycles.
//   Arbitration in IDLE:
//     - only one req high -> grant it
//     - both high -> DM, unless streak==STARVE_MAX, then IF
//   streak: +1 on each DM grant made while if_req=1, saturating at STARVE_MAX.
//     Cleared on an IF grant, and on a DM grant with if_req=0.
//   req dropped mid-access: the access still completes and the ack still pulses.
//     A requester must not change its inputs before its ack.
//   Req still high in the cycle after the ack: treated as a new request.
//   IF never writes: mem_we=0 whenever owner=0.
//   if_rdata/dm_rdata keep their value between acks; writes never update dm_rdata.
// TESTING (MEM_LAT=2, STARVE_MAX=2)
//   1. IF read 0x10, mem_rdata=0x20020005 in the 2nd ACCESS cycle -> mem_en high 2 cycles,
//      then if_ack=1 and if_rdata=0x20020005 for one cycle; dm_ack stays 0.
//   2. if_req and dm_req (write 0x40, 0xDEADBEEF) raised in the same cycle -> DM granted first
//      (mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF), dm_ack; IF granted on the next IDLE.
//   3. dm_req and if_req held continuously -> grant order DM, DM, IF, DM, DM, IF.
//   4. RESET=0 in the 1st ACCESS cycle of a DM write -> mem_en/mem_we/busy go 0 immediately,
//      no ack; after release, state is IDLE and a pending request is granted normally.
//   5. dm_req dropped in the 1st ACCESS cycle of a DM read -> access still completes,
//      dm_ack pulses with captured data, then IDLE.
//   6. IF-only back-to-back reads 0x0, 0x4 -> acks 4 cycles apart; if_rdata holds between acks.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction-fetch (IF) and data (DM) ports.
// DM wins ties until it has taken STARVE_MAX grants in a row over a waiting IF.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              owner_o
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW    = $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(MEM_LAT - 1);
  localparam logic [SW-1:0]    STREAK_MAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e             state_q;
  logic [LAT_W-1:0]   lat_cnt_q;
  logic [SW-1:0]      streak_q;
  logic [SW-1:0]      streak_d;
  logic               owner_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  if_rdata_q;
  logic [DATA_W-1:0]  dm_rdata_q;
  logic               if_ack_q;
  logic               dm_ack_q;
  logic               mem_en_q;
  logic               mem_we_q;
  logic               busy_q;
  logic               grant_dm;

  // IF only overtakes a pending DM once the DM streak has hit its ceiling.
  assign grant_dm = dm_req_i & (~if_req_i | (streak_q != STREAK_MAX));

  always_comb begin
    streak_d = '0;
    if (grant_dm && if_req_i) begin
      streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      streak_q   <= '0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (if_req_i || dm_req_i) begin
            state_q   <= ACCESS;
            lat_cnt_q <= '0;
            streak_q  <= streak_d;
            owner_q   <= grant_dm;
            we_q      <= grant_dm & dm_we_i;
            addr_q    <= grant_dm ? dm_addr_i : if_addr_i;
            if (grant_dm) wdata_q <= dm_wdata_i;
            mem_en_q  <= 1'b1;
            mem_we_q  <= grant_dm & dm_we_i;
            busy_q    <= 1'b1;
          end
        end
        ACCESS: begin
          if (lat_cnt_q == LAT_LAST) begin
            state_q  <= RESP;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (!we_q) begin
              if (owner_q) dm_rdata_q <= mem_rdata_i;
              else         if_rdata_q <= mem_rdata_i;
            end
            if (owner_q) dm_ack_q <= 1'b1;
            else         if_ack_q <= 1'b1;
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = busy_q;
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, checked against
// a transaction-level schedule model (free slot -> grant -> MEM_LAT enables -> ack).
module tb_mem_port_arbiter;
  localparam int LAT  = 2;
  localparam int SMAX = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_ack, dm_req, dm_we, dm_ack;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic        mem_en, mem_we, busy, owner;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_ack_o(dm_ack), .dm_rdata_o(dm_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .busy_o(busy), .owner_o(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        if_q[$], dm_q[$];
  txn_t        if_cur, dm_cur;
  logic [31:0] mem [256];
  int          passed = 0, total = 0;
  int          cyc = 0, k = 0, streak = 0;
  bit          granted_now = 0;
  bit          cur_dm = 0, cur_we = 0;
  logic [31:0] cur_addr = '0, cur_wdata = '0, cur_rd = '0;
  logic [31:0] exp_if_rd = '0, exp_dm_rd = '0;
  int          if_st = 0, dm_st = 0;  // 0 idle, 1 waiting, 2 granted, 3 granted but req dropped
  int          p_issue = 100, p_drop = 0;
  bit          drop_once = 0, rst_once = 0, log_on = 0;
  logic        gnt_log[$];
  int          ack_cyc[$];
  int          en_cnt = 0;
  logic        pat3 [6];
  logic        pat2 [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic push_if(input logic [31:0] a);
    txn_t t;
    t.we = 1'b0; t.addr = a; t.wdata = '0;
    if_q.push_back(t);
  endtask

  task automatic push_dm(input logic w, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.we = w; t.addr = a; t.wdata = d;
    dm_q.push_back(t);
  endtask

  function automatic bit idle_now();
    return (k == 0) && !granted_now && (if_st == 0) && (dm_st == 0) &&
           (if_q.size() == 0) && (dm_q.size() == 0);
  endfunction

  task automatic step();
    bit go_dm;
    @(posedge clk); #1; cyc++;
    if (granted_now) k = 1;
    else if (k == LAT + 1) k = 0;
    else if (k > 0) k++;
    granted_now = 0;
    if (k == LAT + 1 && !cur_we) begin
      if (cur_dm) exp_dm_rd = cur_rd; else exp_if_rd = cur_rd;
    end

    chk("busy", busy, k != 0);
    chk("mem_en", mem_en, k >= 1 && k <= LAT);
    chk("mem_we", mem_we, k >= 1 && k <= LAT && cur_we);
    chk("if_ack", if_ack, k == LAT + 1 && !cur_dm);
    chk("dm_ack", dm_ack, k == LAT + 1 && cur_dm);
    if (k != 0) begin
      chk("owner", owner, cur_dm);
      chk("mem_addr", mem_addr, cur_addr);
      if (cur_we) chk("mem_wdata", mem_wdata, cur_wdata);
    end
    chk("if_rdata", if_rdata, exp_if_rd);
    chk("dm_rdata", dm_rdata, exp_dm_rd);
    if (mem_en) en_cnt++;
    if (log_on && k == 1) gnt_log.push_back(owner);
    if (log_on && if_ack) ack_cyc.push_back(cyc);

    mem_rdata = mem[mem_addr[9:2]];
    if (k == LAT) begin
      if (cur_we) mem[cur_addr[9:2]] = cur_wdata;
      else        cur_rd = mem[cur_addr[9:2]];
    end

    if (rst_once && k == 1 && cur_dm && cur_we) begin
      rst_once = 0;
      rst_n = 1'b0;
      #1;
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dm_ack", dm_ack, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_dm_rdata", dm_rdata, 0);
      rst_n = 1'b1;
      k = 0; streak = 0; exp_if_rd = '0; exp_dm_rd = '0;
      if (dm_st == 2) dm_st = 1; else if (dm_st == 3) dm_st = 0;
      if (if_st == 2) if_st = 1; else if (if_st == 3) if_st = 0;
    end

    if (k == LAT + 1) begin
      if (cur_dm) begin dm_st = 0; dm_req = 1'b0; end
      else        begin if_st = 0; if_req = 1'b0; end
    end
    if (k == 1 && cur_dm && dm_st == 2 && (drop_once || $urandom_range(99) < p_drop)) begin
      drop_once = 0; dm_req = 1'b0; dm_st = 3;
    end
    if (k == 1 && !cur_dm && if_st == 2 && $urandom_range(99) < p_drop) begin
      if_req = 1'b0; if_st = 3;
    end
    if (if_st == 0 && if_q.size() > 0 && $urandom_range(99) < p_issue) begin
      if_cur = if_q.pop_front();
      if_req = 1'b1; if_addr = if_cur.addr; if_st = 1;
    end
    if (dm_st == 0 && dm_q.size() > 0 && $urandom_range(99) < p_issue) begin
      dm_cur = dm_q.pop_front();
      dm_req = 1'b1; dm_we = dm_cur.we; dm_addr = dm_cur.addr; dm_wdata = dm_cur.wdata; dm_st = 1;
    end

    // A free slot with someone waiting: the model decides who owns the next access.
    if (k == 0 && (if_st == 1 || dm_st == 1)) begin
      go_dm = (dm_st == 1) && (if_st != 1 || streak < SMAX);
      if (go_dm && if_st == 1) streak = (streak < SMAX) ? streak + 1 : streak;
      else streak = 0;
      cur_dm = go_dm;
      if (go_dm) begin
        cur_we = dm_cur.we; cur_addr = dm_cur.addr; cur_wdata = dm_cur.wdata; dm_st = 2;
      end else begin
        cur_we = 1'b0; cur_addr = if_cur.addr; if_st = 2;
      end
      granted_now = 1;
    end
  endtask

  task automatic run_idle(input int maxc);
    int n = 0;
    do begin
      step();
      n++;
    end while (!idle_now() && n < maxc);
    chk("drain_timeout", idle_now(), 1);
  endtask

  initial begin
    pat3 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    pat2 = '{1'b1, 1'b0};
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[4] = 32'h2002_0005;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_if_ack", if_ack, 0);
    chk("reset_dm_ack", dm_ack, 0);
    chk("reset_if_rdata", if_rdata, 0);
    chk("reset_dm_rdata", dm_rdata, 0);
    chk("reset_mem_en", mem_en, 0);
    chk("reset_mem_we", mem_we, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_wdata", mem_wdata, 0);
    chk("reset_busy", busy, 0);
    chk("reset_owner", owner, 0);
    rst_n = 1'b1;

    // Single IF read.
    en_cnt = 0;
    push_if(32'h10);
    run_idle(50);
    chk("t1_en_cycles", en_cnt, 2);
    chk("t1_if_rdata", if_rdata, 32'h2002_0005);

    // Simultaneous IF read and DM write: DM first.
    log_on = 1; gnt_log.delete();
    push_dm(1'b1, 32'h40, 32'hDEAD_BEEF);
    push_if(32'h44);
    run_idle(50);
    chk("t2_grants", gnt_log.size(), 2);
    for (int i = 0; i < 2 && i < gnt_log.size(); i++) chk("t2_order", gnt_log[i], pat2[i]);

    // Both held continuously: starvation limit lets IF in every third grant.
    gnt_log.delete();
    for (int i = 0; i < 4; i++) push_dm(1'b0, 32'h100 + 32'(4 * i), '0);
    for (int i = 0; i < 2; i++) push_if(32'h200 + 32'(4 * i));
    run_idle(100);
    chk("t3_grants", gnt_log.size(), 6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++) chk("t3_order", gnt_log[i], pat3[i]);

    // Reset in the first ACCESS cycle of a DM write; the request is re-served afterwards.
    rst_once = 1;
    push_dm(1'b1, 32'h80, 32'h1234_5678);
    run_idle(50);
    chk("t4_rst_used", rst_once, 0);
    chk("t4_mem_after", mem[32], 32'h1234_5678);

    // DM read with req dropped during the access.
    drop_once = 1;
    push_dm(1'b0, 32'h40, '0);
    run_idle(50);
    chk("t5_drop_used", drop_once, 0);
    chk("t5_dm_rdata", dm_rdata, 32'hDEAD_BEEF);

    // IF back-to-back reads: acks MEM_LAT+2 apart.
    ack_cyc.delete();
    push_if(32'h0);
    push_if(32'h4);
    run_idle(50);
    chk("t6_acks", ack_cyc.size(), 2);
    if (ack_cyc.size() == 2) chk("t6_spacing", ack_cyc[1] - ack_cyc[0], 4);
    log_on = 0;

    // Random traffic with idle gaps and occasional mid-access drops.
    p_issue = 60; p_drop = 15;
    for (int i = 0; i < 40; i++) begin
      push_if($urandom);
      push_dm(1'($urandom_range(1)), $urandom, $urandom);
    end
    run_idle(3000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
